// File: rtl/serial_tx_fifo.sv
// rtl/serial_tx_fifo.sv - word FIFO feeding an asynchronous-serial transmitter
// Frames go out back-to-back (start, data LSB-first, optional parity, stop bits) while the FIFO holds words.
module serial_tx_fifo #(
   parameter int DATA_WIDTH   = 32,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int DEPTH        = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   input  logic [DATA_WIDTH-1:0]          in_data,
   output logic                           in_ready,
   output logic                           tx,
   output logic                           busy,
   output logic [$clog2(DEPTH+1)-1:0]     fifo_count
);

   localparam int   AW      = $clog2(DEPTH);
   localparam int   NW      = $clog2(DEPTH + 1);
   localparam int   CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int   BW      = $clog2(DATA_WIDTH + 1);
   localparam logic PAR_ODD = 1'(PARITY == 2);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [NW-1:0]         count;
   logic [DATA_WIDTH-1:0] head;
   logic                  push, pop, fifo_empty;

   state_t                state, state_next;
   logic [CW-1:0]         baud_cnt, baud_next;
   logic [BW-1:0]         bit_cnt, bit_next;
   logic [DATA_WIDTH-1:0] shift_reg, shift_next;
   logic                  par_bit, par_next;
   logic                  tx_reg, tx_next;
   logic                  bit_end, last_data, last_stop, load;

   // A full FIFO refuses pushes even when a pop happens in the same cycle.
   assign in_ready   = (count != NW'(DEPTH));
   assign push       = in_valid && in_ready;
   assign fifo_empty = (count == '0);
   assign head       = mem[rd_ptr];
   assign fifo_count = count;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + NW'(1);
            2'b01:   count <= count - NW'(1);
            default: count <= count;
         endcase
      end
   end

   assign bit_end   = (baud_cnt == CW'(CLKS_PER_BIT - 1));
   assign last_data = (bit_cnt == BW'(DATA_WIDTH - 1));
   assign last_stop = (bit_cnt == BW'(STOP_BITS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         par_bit   <= 1'b0;
         tx_reg    <= 1'b1;
      end else begin
         state     <= state_next;
         baud_cnt  <= baud_next;
         bit_cnt   <= bit_next;
         shift_reg <= shift_next;
         par_bit   <= par_next;
         tx_reg    <= tx_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) state_next = S_START;
         end
         S_START: begin
            if (bit_end) state_next = S_DATA;
         end
         S_DATA: begin
            if (bit_end && last_data) state_next = (PARITY != 0) ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            if (bit_end) state_next = S_STOP;
         end
         S_STOP: begin
            if (bit_end && last_stop) state_next = fifo_empty ? S_IDLE : S_START;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // tx is registered, so each branch sets the level for the bit that starts at this edge.
   always_comb begin
      load       = ((state == S_IDLE) || (state == S_STOP)) && (state_next == S_START);
      pop        = load;
      tx_next    = tx_reg;
      shift_next = shift_reg;
      par_next   = par_bit;
      bit_next   = bit_cnt;
      baud_next  = (bit_end || state == S_IDLE) ? '0 : baud_cnt + CW'(1);
      case (state)
         S_START: begin
            if (bit_end) begin
               tx_next    = shift_reg[0];
               shift_next = shift_reg >> 1;
               bit_next   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (last_data) begin
                  tx_next  = (PARITY != 0) ? par_bit : 1'b1;
                  bit_next = '0;
               end else begin
                  tx_next    = shift_reg[0];
                  shift_next = shift_reg >> 1;
                  bit_next   = bit_cnt + BW'(1);
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               tx_next  = 1'b1;
               bit_next = '0;
            end
         end
         S_STOP: begin
            if (bit_end && !last_stop) begin
               bit_next = bit_cnt + BW'(1);
            end else if (bit_end) begin
               tx_next = 1'b1;
            end
         end
         default: begin
         end
      endcase
      if (load) begin
         shift_next = head;
         par_next   = (^head) ^ PAR_ODD;
         tx_next    = 1'b0;
         bit_next   = '0;
      end
   end

   assign tx   = tx_reg;
   assign busy = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_serial_tx_fifo.sv
// tb/tb_serial_tx_fifo.sv - directed bench for serial_tx_fifo
// Three configurations share one clock and reset; the monitored tx line is selected by sel.
module tb_serial_tx_fifo;

   logic        clk = 1'b0;
   logic        rst;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          sel = 0;
   int          bad;
   logic        tx_mon;

   logic        va, ra, tx_a, ba;
   logic [7:0]  da;
   logic [2:0]  ca;
   logic        vb, rb, tx_b, bb;
   logic [7:0]  db;
   logic [2:0]  cb;
   logic        vc, rc, tx_c, bc;
   logic [31:0] dc;
   logic [2:0]  cc;

   always #5 clk = ~clk;

   serial_tx_fifo #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .DEPTH(4)) u_a (
      .clk(clk), .reset(rst), .in_valid(va), .in_data(da), .in_ready(ra),
      .tx(tx_a), .busy(ba), .fifo_count(ca));

   serial_tx_fifo #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY(2), .STOP_BITS(1), .DEPTH(4)) u_b (
      .clk(clk), .reset(rst), .in_valid(vb), .in_data(db), .in_ready(rb),
      .tx(tx_b), .busy(bb), .fifo_count(cb));

   serial_tx_fifo #(.DATA_WIDTH(32), .CLKS_PER_BIT(2), .PARITY(0), .STOP_BITS(2), .DEPTH(4)) u_c (
      .clk(clk), .reset(rst), .in_valid(vc), .in_data(dc), .in_ready(rc),
      .tx(tx_c), .busy(bc), .fifo_count(cc));

   always_comb begin
      case (sel)
         0:       tx_mon = tx_a;
         1:       tx_mon = tx_b;
         default: tx_mon = tx_c;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // bit 0 = start, then data LSB-first, parity if enabled, stop bits (all remaining ones)
   function automatic logic [63:0] mk_frame(input logic [31:0] d, input int dw, input int par);
      logic [63:0] f;
      logic        p;
      f    = '1;
      f[0] = 1'b0;
      p    = 1'b0;
      for (int i = 0; i < dw; i++) begin
         f[1 + i] = d[i];
         p        = p ^ d[i];
      end
      if (par == 1) f[1 + dw] = p;
      else if (par == 2) f[1 + dw] = ~p;
      return f;
   endfunction

   // Checks tx_mon once per cycle from the current negedge; returns on the negedge after the last sample.
   task automatic chk_frame(input string tag, input logic [63:0] bits, input int nbits,
                            input int cpb, input int skip);
      for (int s = skip; s < nbits * cpb; s++) begin
         chk($sformatf("%s bit%0d smp%0d", tag, s / cpb, s % cpb), 64'(tx_mon), 64'(bits[s / cpb]));
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1;
      va = 1'b0; da = '0;
      vb = 1'b0; db = '0;
      vc = 1'b0; dc = '0;
      repeat (2) @(negedge clk);
      chk("rst tx_a", 64'(tx_a), 64'(1));
      chk("rst busy_a", 64'(ba), 64'(0));
      chk("rst ready_a", 64'(ra), 64'(1));
      chk("rst count_a", 64'(ca), 64'(0));
      chk("rst tx_b", 64'(tx_b), 64'(1));
      chk("rst count_b", 64'(cb), 64'(0));
      chk("rst tx_c", 64'(tx_c), 64'(1));
      chk("rst busy_c", 64'(bc), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      // single 0xA5 frame, even parity, 44 cycles
      sel = 0;
      va = 1'b1; da = 8'hA5;
      @(negedge clk);
      va = 1'b0;
      chk("a5 count latency", 64'(ca), 64'(1));
      chk("a5 tx idle before pop", 64'(tx_a), 64'(1));
      @(negedge clk);
      chk("a5 busy", 64'(ba), 64'(1));
      chk("a5 count after pop", 64'(ca), 64'(0));
      chk_frame("a5", mk_frame(32'hA5, 8, 1), 11, 4, 0);
      chk("a5 busy end", 64'(ba), 64'(0));
      chk("a5 tx end", 64'(tx_a), 64'(1));

      // hold in_valid with words 1..6 against a depth-4 FIFO
      va = 1'b1; da = 8'd1;
      chk("fill ready0", 64'(ra), 64'(1));
      @(negedge clk);
      chk("fill count1", 64'(ca), 64'(1));
      da = 8'd2;
      @(negedge clk);
      chk("fill count2", 64'(ca), 64'(1));
      chk("fill start smp0", 64'(tx_a), 64'(0));
      da = 8'd3;
      @(negedge clk);
      chk("fill count3", 64'(ca), 64'(2));
      chk("fill start smp1", 64'(tx_a), 64'(0));
      da = 8'd4;
      @(negedge clk);
      chk("fill count4", 64'(ca), 64'(3));
      chk("fill start smp2", 64'(tx_a), 64'(0));
      da = 8'd5;
      @(negedge clk);
      chk("fill count full", 64'(ca), 64'(4));
      chk("fill ready full", 64'(ra), 64'(0));
      chk("fill start smp3", 64'(tx_a), 64'(0));
      da = 8'd6;
      @(negedge clk);
      chk_frame("w1", mk_frame(32'd1, 8, 1), 11, 4, 4);
      chk("w2 pop count", 64'(ca), 64'(3));
      chk("w2 pop ready", 64'(ra), 64'(1));
      chk("w2 start smp0", 64'(tx_a), 64'(0));
      @(negedge clk);
      va = 1'b0;
      chk("w6 accepted count", 64'(ca), 64'(4));
      chk("w6 accepted ready", 64'(ra), 64'(0));
      chk("w2 start smp1", 64'(tx_a), 64'(0));
      @(negedge clk);
      chk_frame("w2", mk_frame(32'd2, 8, 1), 11, 4, 2);
      for (int w = 3; w <= 6; w++) begin
         chk_frame($sformatf("w%0d", w), mk_frame(32'(w), 8, 1), 11, 4, 0);
      end
      chk("fill busy end", 64'(ba), 64'(0));
      chk("fill count end", 64'(ca), 64'(0));
      chk("fill tx end", 64'(tx_a), 64'(1));

      // odd parity at one clock per bit, push+pop at the stop-bit boundary
      sel = 1;
      vb = 1'b1; db = 8'h01;
      @(negedge clk);
      chk("b count1", 64'(cb), 64'(1));
      chk("b tx idle", 64'(tx_b), 64'(1));
      db = 8'h03;
      @(negedge clk);
      vb = 1'b0;
      chk("b push+pop count", 64'(cb), 64'(1));
      chk_frame("b01", mk_frame(32'h01, 8, 2), 10, 1, 0);
      chk("b01 stop", 64'(tx_b), 64'(1));
      chk("b count before stop edge", 64'(cb), 64'(1));
      vb = 1'b1; db = 8'h07;
      @(negedge clk);
      vb = 1'b0;
      chk("b count after stop edge", 64'(cb), 64'(1));
      chk_frame("b03", mk_frame(32'h03, 8, 2), 11, 1, 0);
      chk("b count last pop", 64'(cb), 64'(0));
      chk_frame("b07", mk_frame(32'h07, 8, 2), 11, 1, 0);
      chk("b busy end", 64'(bb), 64'(0));
      chk("b tx end", 64'(tx_b), 64'(1));

      // 32-bit words with two stop bits, 35 bit times each, back to back
      sel = 2;
      vc = 1'b1; dc = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("c count1", 64'(cc), 64'(1));
      dc = 32'h0000_0000;
      @(negedge clk);
      vc = 1'b0;
      chk("c push+pop count", 64'(cc), 64'(1));
      chk_frame("cFF", mk_frame(32'hFFFF_FFFF, 32, 0), 35, 2, 0);
      chk_frame("c00", mk_frame(32'h0000_0000, 32, 0), 35, 2, 0);
      chk("c busy end", 64'(bc), 64'(0));

      // reset in the middle of DATA with two words queued
      vc = 1'b1; dc = 32'h0;
      @(negedge clk);
      dc = 32'h1;
      @(negedge clk);
      dc = 32'h2;
      @(negedge clk);
      vc = 1'b0;
      chk("r queued", 64'(cc), 64'(2));
      repeat (4) @(negedge clk);
      chk("r mid data tx", 64'(tx_c), 64'(0));
      #2 rst = 1'b1;
      #1;
      chk("r async tx", 64'(tx_c), 64'(1));
      chk("r async busy", 64'(bc), 64'(0));
      chk("r async count", 64'(cc), 64'(0));
      chk("r async ready", 64'(rc), 64'(1));
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx_c !== 1'b1 || bc !== 1'b0) bad++;
      end
      chk("r no resume", 64'(bad), 64'(0));
      vc = 1'b1; dc = 32'hA5A5_0F0F;
      @(negedge clk);
      vc = 1'b0;
      chk("r new push count", 64'(cc), 64'(1));
      @(negedge clk);
      chk_frame("cA5", mk_frame(32'hA5A5_0F0F, 32, 0), 35, 2, 0);
      chk("r busy end", 64'(bc), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
